// File: rtl/alu_writeback.sv
// Writeback stage: takes arithmetic results, writes them to the register file
// (two bytes for MUL) and keeps the NZVC flags and a count of committed writes.
module alu_writeback #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [15:0]   result,
  input  logic [3:0]    nzvc_in,
  input  logic [AW-1:0] dest,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [7:0]    rf_wdata,
  output logic [3:0]    flags,
  output logic [7:0]    wb_count
);

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_LO = 2'd1,
    S_WR_HI = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_op_p1;
  logic [15:0]   r_result_p1;
  logic [AW-1:0] r_dest_p1;
  logic          w_mul_p1;
  logic          w_xfer;
  logic          w_we_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [7:0]    w_wdata_nxt;

  function automatic logic [AW-1:0] next_reg(input logic [AW-1:0] a);
    return a + 1'b1;
  endfunction

  assign w_mul_p1 = (r_op_p1 == OP_MUL);
  assign w_xfer   = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_WR_LO: in_ready = ~w_mul_p1;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = rf_addr;
    w_wdata_nxt = rf_wdata;
    // A MUL in WR_LO always finishes with its high byte; otherwise any
    // accepted non-CMP result starts (or continues) a low-byte write.
    if (r_state == S_WR_LO && w_mul_p1) begin
      w_state_nxt = S_WR_HI;
      w_we_nxt    = 1'b1;
      w_addr_nxt  = next_reg(r_dest_p1);
      w_wdata_nxt = r_result_p1[15:8];
    end else if (w_xfer && op != OP_CMP) begin
      w_state_nxt = S_WR_LO;
      w_we_nxt    = 1'b1;
      w_addr_nxt  = dest;
      w_wdata_nxt = result[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // capture stage: transaction payload, held while its writes are emitted
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_op_p1     <= op;
      r_result_p1 <= result;
      r_dest_p1   <= dest;
    end
  end

  // write stage: register-file port, flags and commit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= 8'h00;
      flags    <= 4'b0000;
      wb_count <= 8'h00;
    end else begin
      rf_we    <= w_we_nxt;
      rf_addr  <= w_addr_nxt;
      rf_wdata <= w_wdata_nxt;
      if (w_xfer)   flags    <= nzvc_in;
      if (w_we_nxt) wb_count <= wb_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with hand-computed expected values.
module tb_alu_writeback;

  localparam int AW = 3;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DEC = 3'b110;
  localparam logic [2:0] INC = 3'b101, CMP = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'b000;
  logic [15:0]   result = 16'h0000;
  logic [3:0]    nzvc_in = 4'b0000;
  logic [AW-1:0] dest = '0;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [7:0]    rf_wdata;
  logic [3:0]    flags;
  logic [7:0]    wb_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_cnt = 8'd0;

  alu_writeback #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .result(result), .nzvc_in(nzvc_in), .dest(dest),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .flags(flags), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] r, input logic [AW-1:0] d,
                       input logic [3:0] f);
    in_valid = 1'b1; op = o; result = r; dest = d; nzvc_in = f;
  endtask

  task automatic expect_write(input string tag, input logic [AW-1:0] a, input logic [7:0] w,
                              input logic [3:0] f);
    exp_cnt = exp_cnt + 8'd1;
    check({tag, ".we"},    rf_we, 1'b1);
    check({tag, ".addr"},  rf_addr, a);
    check({tag, ".wdata"}, rf_wdata, w);
    check({tag, ".flags"}, flags, f);
    check({tag, ".cnt"},   wb_count, exp_cnt);
  endtask

  initial begin
    // reset with in_valid asserted: nothing may be accepted
    rst = 1'b1;
    drive(ADD, 16'h00AA, 3'd5, 4'b1111);
    step();
    check("rst.ready", in_ready, 1'b0);
    step();
    check("rst.ready2", in_ready, 1'b0);
    check("rst.we", rf_we, 1'b0);
    check("rst.addr", rf_addr, 0);
    check("rst.wdata", rf_wdata, 0);
    check("rst.flags", flags, 0);
    check("rst.cnt", wb_count, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst.ready", in_ready, 1'b1);
    step();
    check("post_rst.we", rf_we, 1'b0);
    check("post_rst.flags", flags, 0);

    // single ADD
    drive(ADD, 16'h0042, 3'd3, 4'b0000);
    step();
    in_valid = 1'b0;
    expect_write("add", 3'd3, 8'h42, 4'b0000);
    step();
    check("idle.we", rf_we, 1'b0);
    check("idle.addr_hold", rf_addr, 3'd3);
    check("idle.wdata_hold", rf_wdata, 8'h42);

    // MUL to reg 7, high byte wraps to reg 0; a pending ADD waits
    drive(MUL, 16'h1234, 3'd7, 4'b0010);
    step();
    drive(ADD, 16'h0099, 3'd5, 4'b1000);
    expect_write("mul.lo", 3'd7, 8'h34, 4'b0010);
    check("mul.lo.ready", in_ready, 1'b0);
    step();
    expect_write("mul.hi", 3'd0, 8'h12, 4'b0010);
    check("mul.hi.ready", in_ready, 1'b0);
    step();
    check("mul.done.we", rf_we, 1'b0);
    check("mul.done.ready", in_ready, 1'b1);
    check("mul.done.flags", flags, 4'b0010);
    step();
    in_valid = 1'b0;
    expect_write("held_add", 3'd5, 8'h99, 4'b1000);

    // back-to-back SUB, DEC, INC
    drive(SUB, 16'h0005, 3'd1, 4'b0000);
    step();
    drive(DEC, 16'h00FF, 3'd2, 4'b1000);
    expect_write("b2b.sub", 3'd1, 8'h05, 4'b0000);
    check("b2b.ready", in_ready, 1'b1);
    step();
    drive(INC, 16'h0000, 3'd4, 4'b0101);
    expect_write("b2b.dec", 3'd2, 8'hFF, 4'b1000);
    step();
    in_valid = 1'b0;
    expect_write("b2b.inc", 3'd4, 8'h00, 4'b0101);

    // CMP between two ADDs
    drive(ADD, 16'h0011, 3'd6, 4'b0000);
    step();
    drive(CMP, 16'h0000, 3'd0, 4'b0100);
    expect_write("cmp.add1", 3'd6, 8'h11, 4'b0000);
    check("cmp.ready1", in_ready, 1'b1);
    step();
    drive(ADD, 16'h0022, 3'd5, 4'b0001);
    check("cmp.we", rf_we, 1'b0);
    check("cmp.flags", flags, 4'b0100);
    check("cmp.ready2", in_ready, 1'b1);
    check("cmp.addr_hold", rf_addr, 3'd6);
    check("cmp.cnt", wb_count, exp_cnt);
    step();
    in_valid = 1'b0;
    expect_write("cmp.add2", 3'd5, 8'h22, 4'b0001);

    // reset during MUL WR_LO aborts the high-byte write
    drive(MUL, 16'hABCD, 3'd2, 4'b0011);
    step();
    in_valid = 1'b0;
    expect_write("abort.lo", 3'd2, 8'hCD, 4'b0011);
    rst = 1'b1;
    step();
    check("abort.rst.ready", in_ready, 1'b0);
    check("abort.we", rf_we, 1'b0);
    check("abort.addr", rf_addr, 0);
    check("abort.wdata", rf_wdata, 0);
    check("abort.flags", flags, 0);
    check("abort.cnt", wb_count, 0);
    rst = 1'b0;
    exp_cnt = 8'd0;
    step();
    check("abort.no_hi.we", rf_we, 1'b0);
    check("abort.no_hi.wdata", rf_wdata, 0);
    check("abort.ready", in_ready, 1'b1);

    // 256 single-byte writes wrap the counter
    for (int i = 0; i < 256; i++) begin
      drive(ADD, 16'(i), AW'(i), 4'(i));
      step();
      if (i == 254) check("wrap.cnt255", wb_count, 8'd255);
    end
    in_valid = 1'b0;
    check("wrap.cnt0", wb_count, 8'd0);
    check("wrap.we", rf_we, 1'b1);
    check("wrap.wdata", rf_wdata, 8'hFF);
    check("wrap.addr", rf_addr, 3'd7);
    step();
    check("wrap.idle.we", rf_we, 1'b0);
    check("wrap.idle.cnt", wb_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
